mult32_seq: RTL

- Sequential shift-add multiplier for the 32-bit ALU.
- Computes a WIDTH x WIDTH product over WIDTH iterations.
- Sits directly upstream of the ALU result-select mux: product_lo bit i drives the MULT input of the bit-i 8:1 result mux.
- The ALU control holds ALU op = MULT until done.

---
 rtl/mult32_pkg.sv | 14 +
 rtl/mult32_ctrl.sv | 72 +++++++
 rtl/mult32_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/mult32_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Optional signed mode is selected by defining MULT32_SIGNED_EN.
package mult32_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned CNT_W      = $clog2(MULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage : mult32_pkg

// File: rtl/mult32_ctrl.sv
// Sequencer for mult32_seq: FSM, iteration counter and datapath strobes.
// busy/done are registered alongside the state.
module mult32_ctrl
    import mult32_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mult_state_t   state;
    logic [CW-1:0] cnt;

    // start is honoured in IDLE and DONE (back-to-back), never while iterating
    assign load   = start && (state != CALC);
    assign step   = (state == CALC);
    assign finish = step && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CALC;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CALC;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : mult32_ctrl

// File: rtl/mult32_seq.sv
// Sequential shift-add multiplier feeding the ALU result-select mux.
// Define MULT32_SIGNED_EN for two's-complement operands; default is unsigned.
module mult32_seq
    import mult32_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    logic load;
    logic step;
    logic finish;

    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] p_shift;
    logic [WIDTH-1:0]   a_op;
    logic [WIDTH-1:0]   b_op;

    mult32_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .load   (load),
        .step   (step),
        .finish (finish),
        .busy   (busy),
        .done   (done)
    );

`ifdef MULT32_SIGNED_EN
    logic sign;

    // Negating the most negative value wraps to itself, which read unsigned is 2^(W-1)
    assign a_op = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_op = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign <= 1'b0;
        end else if (load) begin
            sign <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_op = a;
    assign b_op = b;
`endif

    // Upper-half add keeps its carry, which becomes the MSB after the shift
    always_comb begin
        sum = {1'b0, p[2*WIDTH-1:WIDTH]};
        if (p[0]) begin
            sum = sum + {1'b0, m};
        end
        p_shift = {sum, p[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
            p <= '0;
        end else if (load) begin
            m <= a_op;
            p <= {{WIDTH{1'b0}}, b_op};
        end else if (step) begin
`ifdef MULT32_SIGNED_EN
            if (finish && sign) begin
                p <= ~p_shift + (2*WIDTH)'(1);
            end else begin
                p <= p_shift;
            end
`else
            p <= p_shift;
`endif
        end
    end

`ifndef MULT32_SIGNED_EN
    // finish only matters for the signed fix-up
    logic unused_finish;
    assign unused_finish = finish;
`endif

    assign product_lo = p[WIDTH-1:0];
    assign product_hi = p[2*WIDTH-1:WIDTH];

endmodule : mult32_seq
